// File: rtl/superscalar_stack_pkg.sv
// Shared types and helpers for the dual-lane stack.
// Contents:
//   lane_op_e   - per-lane operation decoded from a push/pop request pair
//   lane_decode - maps (push, pop) to a lane_op_e
package superscalar_stack_pkg;

    typedef enum logic [1:0] {
        NOP     = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        ILLEGAL = 2'd3
    } lane_op_e;

    // Push and pop together on one lane is not a valid instruction.
    function automatic lane_op_e lane_decode(input logic push, input logic pop);
        lane_op_e op;
        op = NOP;
        if (push && pop) begin
            op = ILLEGAL;
        end else if (push) begin
            op = PUSH;
        end else if (pop) begin
            op = POP;
        end
        return op;
    endfunction

endpackage

// File: rtl/superscalar_stack_if.sv
// Request/response bundle for superscalar_stack.
// Parameters: WIDTH (data bits), DEPTH (entries, power of two >= 4).
// master (requester) drives: push0, pop0, push1, pop1, wdata0, wdata1, err_clr
// slave  (stack)     drives: rdata0, rdata1, rvalid0, rvalid1, count, full,
//                            empty, ovf, udf, illegal
interface superscalar_stack_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             push0;
    logic             pop0;
    logic             push1;
    logic             pop1;
    logic [WIDTH-1:0] wdata0;
    logic [WIDTH-1:0] wdata1;
    logic [WIDTH-1:0] rdata0;
    logic [WIDTH-1:0] rdata1;
    logic             rvalid0;
    logic             rvalid1;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             udf;
    logic             illegal;
    logic             err_clr;

    modport master (
        output push0, pop0, push1, pop1, wdata0, wdata1, err_clr,
        input  rdata0, rdata1, rvalid0, rvalid1, count, full, empty,
               ovf, udf, illegal
    );

    modport slave (
        input  push0, pop0, push1, pop1, wdata0, wdata1, err_clr,
        output rdata0, rdata1, rvalid0, rvalid1, count, full, empty,
               ovf, udf, illegal
    );

endinterface

// File: rtl/superscalar_stack_mem.sv
// Stack storage: 2 synchronous write ports, 2 asynchronous read ports.
// Ports:
//   clk                    - write clock
//   we0/waddr0/wdata0      - write port 0
//   we1/waddr1/wdata1      - write port 1 (wins on an address collision)
//   raddr0/rdata0          - async read port 0
//   raddr1/rdata1          - async read port 1
// Contents are not reset.
module superscalar_stack_mem #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input  logic                       clk,
    input  logic                       we0,
    input  logic [$clog2(DEPTH)-1:0]   waddr0,
    input  logic [WIDTH-1:0]           wdata0,
    input  logic                       we1,
    input  logic [$clog2(DEPTH)-1:0]   waddr1,
    input  logic [WIDTH-1:0]           wdata1,
    input  logic [$clog2(DEPTH)-1:0]   raddr0,
    output logic [WIDTH-1:0]           rdata0,
    input  logic [$clog2(DEPTH)-1:0]   raddr1,
    output logic [WIDTH-1:0]           rdata1
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write ports; the control logic never targets one slot twice per cycle.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/superscalar_stack.sv
// Dual-issue LIFO stack: two lanes per cycle, lane 0 applied before lane 1.
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   bus   - superscalar_stack_if.slave: per-lane push/pop requests and data,
//           registered pop data/valids, occupancy, full/empty, error flags
// Parameters WIDTH/DEPTH must match those of the connected interface.
// Build option: SSTACK_STICKY_ERR_EN makes ovf/udf/illegal sticky until
// err_clr or rst; otherwise they are one-cycle pulses and err_clr is ignored.
module superscalar_stack
    import superscalar_stack_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1024
) (
    input logic                clk,
    input logic                rst,
    superscalar_stack_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // Registered state
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] rdata0_q;
    logic [WIDTH-1:0] rdata1_q;
    logic             rvalid0_q;
    logic             rvalid1_q;
    logic             ovf_q;
    logic             udf_q;
    logic             illegal_q;

    // Per-cycle decode results
    lane_op_e         op0;
    lane_op_e         op1;
    logic [CW-1:0]    occ1;
    logic [CW-1:0]    occ_next;
    logic             we0;
    logic             we1;
    logic [AW-1:0]    waddr0;
    logic [AW-1:0]    waddr1;
    logic [AW-1:0]    raddr0;
    logic [AW-1:0]    raddr1;
    logic [WIDTH-1:0] mem_rdata0;
    logic [WIDTH-1:0] mem_rdata1;
    logic             pop0_ok;
    logic             pop1_ok;
    logic             fwd1;
    logic             ovf_ev;
    logic             udf_ev;
    logic             ill_ev;

    // Lane sequencing: lane 1 sees the occupancy left by lane 0.
    always_comb begin
        op0      = lane_decode(bus.push0, bus.pop0);
        op1      = lane_decode(bus.push1, bus.pop1);
        occ1     = count_q;
        occ_next = count_q;
        we0      = 1'b0;
        we1      = 1'b0;
        waddr0   = AW'(count_q);
        waddr1   = AW'(count_q);
        raddr0   = AW'(count_q - CW'(1));
        raddr1   = AW'(count_q - CW'(1));
        pop0_ok  = 1'b0;
        pop1_ok  = 1'b0;
        fwd1     = 1'b0;
        ovf_ev   = 1'b0;
        udf_ev   = 1'b0;
        ill_ev   = 1'b0;

        if ((op0 == PUSH) && (op1 == POP)) begin
            // Lane 1 consumes lane 0's push directly; memory and count are
            // untouched, so this is accepted even at full occupancy.
            pop1_ok = 1'b1;
            fwd1    = 1'b1;
        end else begin
            case (op0)
                PUSH: begin
                    if (count_q == CW'(DEPTH)) begin
                        ovf_ev = 1'b1;
                    end else begin
                        we0    = 1'b1;
                        waddr0 = AW'(count_q);
                        occ1   = count_q + CW'(1);
                    end
                end
                POP: begin
                    if (count_q == CW'(0)) begin
                        udf_ev = 1'b1;
                    end else begin
                        pop0_ok = 1'b1;
                        occ1    = count_q - CW'(1);
                    end
                end
                ILLEGAL: ill_ev = 1'b1;
                default: ;
            endcase

            occ_next = occ1;
            case (op1)
                PUSH: begin
                    if (occ1 == CW'(DEPTH)) begin
                        ovf_ev = 1'b1;
                    end else begin
                        we1      = 1'b1;
                        waddr1   = AW'(occ1);
                        occ_next = occ1 + CW'(1);
                    end
                end
                POP: begin
                    if (occ1 == CW'(0)) begin
                        udf_ev = 1'b1;
                    end else begin
                        pop1_ok  = 1'b1;
                        raddr1   = AW'(occ1 - CW'(1));
                        occ_next = occ1 - CW'(1);
                    end
                end
                ILLEGAL: ill_ev = 1'b1;
                default: ;
            endcase
        end
    end

    // Storage; writes are suppressed while reset discards the cycle's requests.
    superscalar_stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we0    (we0 & ~rst),
        .waddr0 (waddr0),
        .wdata0 (bus.wdata0),
        .we1    (we1 & ~rst),
        .waddr1 (waddr1),
        .wdata1 (bus.wdata1),
        .raddr0 (raddr0),
        .rdata0 (mem_rdata0),
        .raddr1 (raddr1),
        .rdata1 (mem_rdata1)
    );

    // Occupancy and pop results; rdata holds its value when no pop is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            count_q   <= occ_next;
            rvalid0_q <= pop0_ok;
            rvalid1_q <= pop1_ok;
            if (pop0_ok) begin
                rdata0_q <= mem_rdata0;
            end
            if (pop1_ok) begin
                rdata1_q <= fwd1 ? bus.wdata0 : mem_rdata1;
            end
        end
    end

    // Error flags; a new error outranks err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
`ifdef SSTACK_STICKY_ERR_EN
            ovf_q     <= ovf_ev | (ovf_q     & ~bus.err_clr);
            udf_q     <= udf_ev | (udf_q     & ~bus.err_clr);
            illegal_q <= ill_ev | (illegal_q & ~bus.err_clr);
`else
            ovf_q     <= ovf_ev;
            udf_q     <= udf_ev;
            illegal_q <= ill_ev;
`endif
        end
    end

`ifndef SSTACK_STICKY_ERR_EN
    // err_clr has no effect when the flags are pulses.
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;
`endif

    assign bus.count   = count_q;
    assign bus.rdata0  = rdata0_q;
    assign bus.rdata1  = rdata1_q;
    assign bus.rvalid0 = rvalid0_q;
    assign bus.rvalid1 = rvalid1_q;
    assign bus.full    = (count_q == CW'(DEPTH));
    assign bus.empty   = (count_q == CW'(0));
    assign bus.ovf     = ovf_q;
    assign bus.udf     = udf_q;
    assign bus.illegal = illegal_q;

endmodule

// File: doc/superscalar_stack.md
SUPERSCALAR_STACK -- requirements
Module: superscalar_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning entry count; legal values are powers of two and at least 4.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports push0, pop0, push1, pop1, inputs, 1 bit each: per-lane operation requests; lane 0 is the older instruction.
REQ-006 SHALL have ports wdata0 and wdata1, inputs, WIDTH bits each: per-lane push data.
REQ-007 SHALL have ports rdata0 and rdata1, outputs, WIDTH bits each: registered per-lane pop data.
REQ-008 SHALL have ports rvalid0 and rvalid1, outputs, 1 bit each: the matching rdata carries accepted pop data.
REQ-009 SHALL have port count, output, $clog2(DEPTH)+1 bits: current occupancy.
REQ-010 SHALL have ports full and empty, outputs, 1 bit each: count==DEPTH and count==0, combinational from count.
REQ-011 SHALL have ports ovf, udf and illegal, outputs, 1 bit each: error flags.
REQ-012 SHALL have port err_clr, input, 1 bit: clears the sticky error flags.

Function
REQ-013 SHALL apply the lane operations in order each cycle, lane 0 then lane 1; lane 1 sees the occupancy left by lane 0.
REQ-014 SHALL treat a lane with both push and pop asserted as a no-op for that lane and raise illegal.
REQ-015 SHALL reject a push when occupancy at that lane is DEPTH; a rejected push writes nothing, leaves count unchanged and raises ovf.
REQ-016 SHALL reject a pop when occupancy at that lane is 0; a rejected pop leaves rvalid low and raises udf.
REQ-017 SHALL write two pushes to mem[count] and mem[count+1]; with count==DEPTH-1, SHALL accept only push0.
REQ-018 SHALL return two pops as rdata0=mem[count-1] and rdata1=mem[count-2]; with count==1, SHALL accept only pop0.
REQ-019 SHALL forward push0 plus pop1 as rdata1=wdata0, with no memory write and count unchanged, even when full.
REQ-020 SHALL handle pop0 plus push1 as follows: rdata0=old top, wdata1 written to the same slot, count unchanged, even when empty is false.
REQ-021 SHALL present pop results one cycle after the request, registered: rvalid pulses for one cycle, and rdata holds its last value when rvalid is low.
REQ-022 SHALL update count by the net accepted pushes minus accepted pops, in the range -2..+2, with no wrap-around.

Reset
REQ-023 SHALL, while rst is high at a rising edge, clear count, rvalid0/1, rdata0/1 (to 0) and all error flags, and discard requests in that cycle.
REQ-024 SHALL NOT clear memory contents on reset; entries above count are don't-care.

Configuration
REQ-025 With macro SSTACK_STICKY_ERR_EN defined, ovf, udf and illegal SHALL be sticky until err_clr or rst; err_clr in the same cycle as a new error SHALL leave the flag set.
REQ-026 Without SSTACK_STICKY_ERR_EN, ovf, udf and illegal SHALL be registered one-cycle pulses for the offending cycle, and err_clr SHALL be ignored.

Structure
REQ-027 Package superscalar_stack_pkg SHALL hold the lane operation enum (NOP, PUSH, POP, ILLEGAL) and the lane decode function.
REQ-028 Storage SHALL be a sub-module superscalar_stack_mem with 2 write ports and 2 asynchronous read ports, parameterised by WIDTH and DEPTH; the pointer and control logic SHALL stay in the top module.

Verification (DEPTH=4, WIDTH=32)
REQ-029 Reset, then push0=0xA, push1=0xB, then pop0 and pop1 together -> next cycle rdata0=0xB, rdata1=0xA, both rvalid=1, count=0.
REQ-030 At count=3, push0=0x1 and push1=0x2 -> count=4, full=1, ovf=1, and mem[3]=0x1.
REQ-031 At count=1, push0=0x55 and pop1 -> rdata1=0x55 and rvalid1=1 next cycle, count stays 1, old top is untouched.
REQ-032 Top=0x7, pop0 plus push1=0x9 -> rdata0=0x7, count unchanged; a following pop0 returns 0x9.
REQ-033 When empty, pop0 and pop1 -> no rvalid, udf=1; with SSTACK_STICKY_ERR_EN the flag holds until err_clr, without it the flag pulses for one cycle.
REQ-034 push0 and pop0 together while rst is asserted mid-sequence at count=3 -> illegal stays 0, and count=0, rvalid=0 the next cycle.
